// File: rtl/multi_latch_capture_pkg.sv
// Shared encodings and widths for the multi-channel switch capture block.
package multi_latch_capture_pkg;
  localparam logic MODE_PAR = 1'b0;
  localparam logic MODE_SEQ = 1'b1;
  localparam int   CNT_W    = 8;
endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, rising-edge pulse.
module btn_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press,
  output logic level
);
  localparam int            CW      = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic          s1, s2, stable, stable_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      s1       <= btn_raw;
      s2       <= s1;
      stable_d <= stable;
      // Any return to the accepted level restarts the stability window.
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = stable & ~stable_d;
  assign level = stable;
endmodule

// File: rtl/multi_latch_capture.sv
// Captures switch data on debounced button presses, all channels or one per press.
module multi_latch_capture
  import multi_latch_capture_pkg::*;
#(
  parameter int CH_NUM    = 4,
  parameter int CH_W      = 4,
  parameter int DB_CYCLES = 4,
  parameter int PTR_W     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   button,
  input  logic                   mode,
  input  logic                   clr,
  input  logic [CH_NUM*CH_W-1:0] data_in,
  output logic [CH_NUM*CH_W-1:0] data_out,
  output logic                   cap_valid,
  output logic [PTR_W-1:0]       ptr,
  output logic [CNT_W-1:0]       cap_cnt
);
  logic press, level, commit;
  logic [CH_NUM-1:0][CH_W-1:0] ch_in, ch_q;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (button),
    .press   (press),
    .level   (level)
  );

  // clr wins over a coincident press, which is then lost.
  assign commit   = press & level & ~clr;
  assign ch_in    = data_in;
  assign data_out = ch_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q      <= '0;
      cap_valid <= 1'b0;
      ptr       <= '0;
      cap_cnt   <= '0;
    end else begin
      cap_valid <= commit;
      if (clr) begin
        ch_q    <= '0;
        ptr     <= '0;
        cap_cnt <= '0;
      end else if (commit) begin
        cap_cnt <= cap_cnt + 1'b1;
        if (mode == MODE_PAR) begin
          ch_q <= ch_in;
          ptr  <= '0;
        end else begin
          for (int k = 0; k < CH_NUM; k++)
            if (ptr == PTR_W'(k)) ch_q[k] <= ch_in[k];
          ptr <= (ptr == PTR_W'(CH_NUM - 1)) ? '0 : ptr + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_multi_latch_capture.sv
// Directed bench: default 4-channel build plus a 3-channel build sharing the button.
module tb_multi_latch_capture;
  logic        clk, rst_n, button, mode, clr;
  logic [15:0] data_in, data_out;
  logic [11:0] data_in3, data_out3;
  logic        cap_valid, cap_valid3;
  logic [1:0]  ptr, ptr3;
  logic [7:0]  cap_cnt, cap_cnt3;
  int checks = 0, errors = 0;
  int np, fe;

  multi_latch_capture dut (
    .clk(clk), .rst_n(rst_n), .button(button), .mode(mode), .clr(clr),
    .data_in(data_in), .data_out(data_out), .cap_valid(cap_valid),
    .ptr(ptr), .cap_cnt(cap_cnt));

  multi_latch_capture #(.CH_NUM(3), .CH_W(4), .DB_CYCLES(4), .PTR_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .button(button), .mode(mode), .clr(clr),
    .data_in(data_in3), .data_out(data_out3), .cap_valid(cap_valid3),
    .ptr(ptr3), .cap_cnt(cap_cnt3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; button high for 'hold' rising edges, then released
  // long enough for the debounced level to return low.
  task automatic press_btn(input int hold, output int npulse, output int first);
    npulse = 0;
    first  = 0;
    button = 1'b1;
    for (int i = 1; i <= hold + 14; i++) begin
      @(negedge clk);
      if (i == hold) button = 1'b0;
      if (cap_valid) begin
        npulse++;
        if (first == 0) first = i;
      end
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; button = 1'b1; mode = 1'b0; clr = 1'b0;
    data_in = 16'hFFFF; data_in3 = 12'hFFF;

    // Reset with button already high
    repeat (3) @(negedge clk);
    check("rst data_out", data_out, 0);
    check("rst cap_valid", cap_valid, 0);
    check("rst ptr", ptr, 0);
    check("rst cap_cnt", cap_cnt, 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 6) check("rst edge6 no cap", {data_out, 15'd0, cap_valid}, 0);
      if (i == 7) check("rst edge7 cap", {data_out, 15'd0, cap_valid}, {16'hFFFF, 16'd1});
      if (i == 8) check("rst cap_valid 1 cycle", cap_valid, 0);
    end
    check("rst cap_cnt after", cap_cnt, 1);
    button = 1'b0;
    repeat (14) @(negedge clk);

    // Plain clear
    pulse_clr();
    check("clr data_out", data_out, 0);
    check("clr cap_cnt", cap_cnt, 0);

    // Parallel capture, held 20 cycles
    data_in = 16'hA5C3;
    press_btn(20, np, fe);
    check("par first edge", fe, 7);
    check("par pulses", np, 1);
    check("par data_out", data_out, 16'hA5C3);
    check("par cap_cnt", cap_cnt, 1);
    check("par ptr", ptr, 0);

    // Glitches: 3 cycles rejected, 4 accepted
    data_in = 16'h1234;
    press_btn(3, np, fe);
    check("glitch3 pulses", np, 0);
    check("glitch3 data_out", data_out, 16'hA5C3);
    check("glitch3 cap_cnt", cap_cnt, 1);
    press_btn(4, np, fe);
    check("hold4 pulses", np, 1);
    check("hold4 first edge", fe, 7);
    check("hold4 data_out", data_out, 16'h1234);
    check("hold4 cap_cnt", cap_cnt, 2);

    // Sequential round-robin on both builds
    pulse_clr();
    mode = 1'b1; data_in = 16'h4321; data_in3 = 12'h321;
    press_btn(7, np, fe);
    check("seq1 ptr3", ptr3, 1);
    check("seq1 data3", data_out3, 12'h001);
    press_btn(7, np, fe);
    check("seq2 ptr3", ptr3, 2);
    check("seq2 data3", data_out3, 12'h021);
    press_btn(7, np, fe);
    check("seq3 ptr3", ptr3, 0);
    check("seq3 data3", data_out3, 12'h321);
    check("seq3 ptr4", ptr, 3);
    check("seq3 data4", data_out, 16'h0321);
    data_in3 = 12'hABC;
    press_btn(7, np, fe);
    check("seq4 ptr3", ptr3, 1);
    check("seq4 data3", data_out3, 12'h32C);
    check("seq4 cnt3", cap_cnt3, 4);
    check("seq4 ptr4", ptr, 0);
    check("seq4 data4", data_out, 16'h4321);

    // clr on the commit edge drops the press
    mode = 1'b0; data_in = 16'h5555;
    button = 1'b1;
    np = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 6) clr = 1'b1;
      if (i == 7) begin
        clr = 1'b0;
        check("clrpress data_out", data_out, 0);
        check("clrpress ptr", ptr, 0);
        check("clrpress cap_cnt", cap_cnt, 0);
      end
      if (i == 10) button = 1'b0;
      if (cap_valid) np++;
    end
    check("clrpress pulses", np, 0);

    // 256 captures wrap the counter
    data_in = 16'h1111;
    for (int n = 0; n < 256; n++) begin
      press_btn(7, np, fe);
      if (n == 254) check("wrap cnt 255", cap_cnt, 255);
    end
    check("wrap cnt 0", cap_cnt, 0);
    check("wrap data_out", data_out, 16'h1111);

    // Mode mix: sequential then parallel
    mode = 1'b1; data_in = 16'h8765;
    press_btn(7, np, fe);
    check("mix seq data", data_out, 16'h1115);
    check("mix seq ptr", ptr, 1);
    mode = 1'b0; data_in = 16'h9ABC;
    press_btn(7, np, fe);
    check("mix par data", data_out, 16'h9ABC);
    check("mix par ptr", ptr, 0);
    check("mix cap_cnt", cap_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_latch_capture.md
Name: multi_latch_capture

Overview:
- Parametrised, multi-channel successor to the single-button switch-latch block.
- An integrated debouncer turns a raw push-button into a one-cycle press pulse.
- On each press, switch data is captured into output registers in one of two modes:
  - parallel: all channels at once;
  - sequential: one channel per press, round-robin.
- Sits between board switches/buttons and downstream display/register logic, all in the clk domain.

Parameters:
- CH_NUM, 4, number of data channels (>=1).
- CH_W, 4, bits per channel (>=1).
- DB_CYCLES, 4, consecutive stable cycles required to accept a button level change (>=2).
- PTR_W, 2, channel pointer width; must satisfy 2**PTR_W >= CH_NUM.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- button  in  1  raw, asynchronous push-button level.
- mode  in  1  0 = parallel capture, 1 = sequential capture; sampled on the capture edge.
- clr  in  1  synchronous clear of captured data and pointer.
- data_in  in  CH_NUM*CH_W  switch data; channel k at bits [k*CH_W +: CH_W].
- data_out  out  CH_NUM*CH_W  captured data, same packing as data_in.
- cap_valid  out  1  one-cycle pulse on the edge a capture commits.
- ptr  out  PTR_W  next channel to load in sequential mode.
- cap_cnt  out  8  captures since reset/clr; wraps 255->0.

Behaviour:
- Reset (rst_n low, async):
  - data_out=0, cap_valid=0, ptr=0, cap_cnt=0.
  - Synchroniser flops=0, debounce counter=0, stable=0, stable_d=0.
- Synchroniser: 2 flops, button -> s1 -> s2.
- Debouncer, each edge:
  - if s2==stable: cnt<=0;
  - else if cnt==DB_CYCLES-1: stable<=s2, cnt<=0;
  - else cnt<=cnt+1.
  - A glitch shorter than DB_CYCLES cycles never changes stable.
- press = stable & ~stable_d, with stable_d registered from stable. Release edges generate nothing.
- Latency: button rising (set up before edge 1) -> data_out update on edge 2+DB_CYCLES+1 (edge 7 at default).
- Priority on each edge: clr > press.
- clr high:
  - data_out<=0, ptr<=0, cap_cnt<=0, cap_valid<=0.
  - A simultaneous press is dropped.
- press & mode==0:
  - data_out<=data_in, ptr<=0.
- press & mode==1:
  - channel ptr of data_out <= channel ptr of data_in; other channels hold.
  - ptr<=(ptr==CH_NUM-1) ? 0 : ptr+1. CH_NUM need not be a power of 2.
- On any committed press: cap_valid<=1 for exactly one cycle, cap_cnt<=cap_cnt+1.
- mode changes between presses are legal; ptr is retained across mode 1 presses and zeroed by any mode 0 press.
- data_in is not synchronised; it is treated as quasi-static while the button is held.
- Holding the button produces exactly one capture. The next capture needs release (stable=0) then press again.
- rst_n asserted mid-debounce discards the pending press. After release, button must be seen low->high again to capture.

Decomposition:
- Shared package/header:
  - mode encodings MODE_PAR=0, MODE_SEQ=1;
  - cap_cnt width constant CNT_W=8.
- One sub-module, btn_debounce: synchroniser + counter + edge detect.
  - Params DB_CYCLES.
  - Ports clk, rst_n, btn_raw, press, level.
  - Reusable by other button-driven blocks.
- Top holds the capture registers, pointer and counter.

Test Plan:
- Reset/idle: rst_n=0 with data_in=16'hFFFF, button=1 -> all outputs 0. Release rst_n with button already high -> one capture on edge 7 after release (level low->high seen only because stable resets to 0).
- Parallel: mode=0, data_in=16'hA5C3, press held 20 cycles -> data_out=16'hA5C3 exactly 7 edges after button rises; cap_valid high one cycle; cap_cnt=1; ptr=0; no second capture while held.
- Glitch: button high for 3 cycles then low (DB_CYCLES=4) -> data_out, cap_valid and cap_cnt unchanged. Repeat with 4+ stable cycles -> capture occurs.
- Sequential wrap: mode=1, CH_NUM=3 build, data_in={4'h3,4'h2,4'h1}, 4 presses -> ptr 0->1->2->0->1. After 3 presses data_out={3,2,1}; 4th press rewrites channel 0 only; cap_cnt=4.
- clr vs press: clr asserted on the press edge -> data_out=0, ptr=0, cap_cnt=0, no cap_valid pulse.
- Counter wrap and mode mix: 256 presses -> cap_cnt=0. Mode 1 press (ptr=1) then mode 0 press -> full load and ptr=0.
